// File: rtl/etai32_reg_adder.sv
// etai32_reg_adder: registered Error-Tolerant Adder type I (ETA-I).
// The upper WIDTH-LOWER bits are added exactly and their carry-out lands in
// adder_out[WIDTH]. The lower LOWER bits are carry-free: plain XOR down to
// the highest bit where both operands are 1; from that bit down, every bit
// is forced to 1. The result is registered, so latency is 1 cycle.
// Optional macro ETAI_ERR_FLAG_EN adds a registered err_flag output. It is
// high when the approximate result differs from the exact sum.
// LOWER must lie in 1..WIDTH-1.
module etai32_reg_adder #(
  parameter int WIDTH = 32,
  parameter int LOWER = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
`ifdef ETAI_ERR_FLAG_EN
  output logic             err_flag,
`endif
  output logic             out_valid,
  output logic [WIDTH:0]   adder_out
);

  logic [LOWER-1:0]     lower_sum;
  logic [WIDTH-LOWER:0] upper_sum;
  logic [WIDTH:0]       approx_d;
  logic [WIDTH:0]       adder_out_q;
  logic                 out_valid_q;

  // Lower part: scan from the MSB down; the first collision saturates the rest
  always_comb begin
    logic sat;
    sat       = 1'b0;
    lower_sum = '0;
    for (int i = LOWER - 1; i >= 0; i--) begin
      if (data_A[i] && data_B[i]) begin
        sat = 1'b1;
      end
      lower_sum[i] = sat | (data_A[i] ^ data_B[i]);
    end
  end

  // Upper part: exact add with zero carry-in; MSB of the sum is the carry-out
  assign upper_sum = {1'b0, data_A[WIDTH-1:LOWER]} + {1'b0, data_B[WIDTH-1:LOWER]};
  assign approx_d  = {upper_sum, lower_sum};

  // Result register: capture on a valid beat, otherwise hold the last result
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      adder_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        adder_out_q <= approx_d;
      end
    end
  end

  assign adder_out = adder_out_q;
  assign out_valid = out_valid_q;

`ifdef ETAI_ERR_FLAG_EN
  logic [WIDTH:0] exact_sum;
  logic           err_d;
  logic           err_flag_q;

  assign exact_sum = {1'b0, data_A} + {1'b0, data_B};
  assign err_d     = (approx_d != exact_sum);

  // Error flag register: tracks adder_out and holds along with it
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_flag_q <= 1'b0;
    end else if (in_valid) begin
      err_flag_q <= err_d;
    end
  end

  assign err_flag = err_flag_q;
`endif

endmodule

// File: tb/tb_etai32_reg_adder.sv
// Testbench for etai32_reg_adder: a reference model computes the expected
// outputs from the adder rules, directed vectors are checked against literal
// values, and randomized traffic is compared on every cycle.
module tb_etai32_reg_adder;

  localparam int W = 32;
  localparam int L = 16;

  logic         Clk;
  logic         Rst_n;
  logic         in_valid;
  logic [W-1:0] data_A;
  logic [W-1:0] data_B;
  logic         out_valid;
  logic [W:0]   adder_out;
`ifdef ETAI_ERR_FLAG_EN
  logic         err_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_sum;
  logic       exp_v;
  logic       exp_err;

  etai32_reg_adder #(.WIDTH(W), .LOWER(L)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .data_A    (data_A),
    .data_B    (data_B),
`ifdef ETAI_ERR_FLAG_EN
    .err_flag  (err_flag),
`endif
    .out_valid (out_valid),
    .adder_out (adder_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: find the highest lower-part collision, set it and every bit
  // below it, and add the upper halves as plain integers.
  function automatic logic [W:0] model_approx(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] lmask;
    logic [W-1:0] coll;
    logic [W-1:0] low;
    logic [W:0]   up;
    int           k;
    lmask = (32'd1 << L) - 32'd1;
    coll  = a & b & lmask;
    low   = (a ^ b) & lmask;
    k     = -1;
    for (int i = 0; i < L; i++) if (coll[i]) k = i;
    if (k >= 0) low = low | ((32'd1 << (k + 1)) - 32'd1);
    up = ({1'b0, a} >> L) + ({1'b0, b} >> L);
    return (up << L) | {1'b0, low};
  endfunction

  // Expected-output tracker
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      exp_sum = '0;
      exp_v   = 1'b0;
      exp_err = 1'b0;
    end else if (in_valid) begin
      exp_sum = model_approx(data_A, data_B);
      exp_v   = 1'b1;
      exp_err = (exp_sum != ({1'b0, data_A} + {1'b0, data_B}));
    end else begin
      exp_v = 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    n_checks++;
    if (out_valid !== exp_v || adder_out !== exp_sum) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got valid=%0b sum=%h, want valid=%0b sum=%h",
               $time, out_valid, adder_out, exp_v, exp_sum);
    end
`ifdef ETAI_ERR_FLAG_EN
    n_checks++;
    if (err_flag !== exp_err) begin
      n_fail++;
      $display("FAIL model_err t=%0t: got %0b want %0b", $time, err_flag, exp_err);
    end
`endif
  end

  task automatic check_out(input string name, input logic v, input logic [W:0] s, input logic e);
    n_checks++;
    if (out_valid !== v || adder_out !== s) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b sum=%h, want valid=%0b sum=%h", name, out_valid, adder_out, v, s);
    end
`ifdef ETAI_ERR_FLAG_EN
    n_checks++;
    if (err_flag !== e) begin
      n_fail++;
      $display("FAIL %s_err: got %0b want %0b", name, err_flag, e);
    end
`endif
  endtask

  // Present operands now (posedge+1); check the registered result one cycle later
  task automatic apply_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W:0] s, input logic e);
    data_A   = a;
    data_B   = b;
    in_valid = 1'b1;
    @(posedge Clk); #1;
    check_out(name, 1'b1, s, e);
  endtask

  initial begin
    Rst_n    = 1'b0;
    in_valid = 1'b1;
    data_A   = $urandom;
    data_B   = $urandom;

    // Reset held with operands changing while the clock runs
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      data_A = $urandom;
      data_B = $urandom;
      check_out("reset_hold", 1'b0, '0, 1'b0);
    end
    // Release mid-cycle with nothing valid: outputs must stay zero
    in_valid = 1'b0;
    #2 Rst_n = 1'b1;
    @(posedge Clk); #1;
    check_out("post_release", 1'b0, '0, 1'b0);

    // Directed vectors, back to back
    apply_check("no_collision", 32'h0000_1234, 32'h0000_0001, 33'h0_0000_1235, 1'b0);
    apply_check("coll_bit0",    32'h0000_00FF, 32'h0000_0001, 33'h0_0000_00FF, 1'b1);
    apply_check("coll_bit15",   32'h0000_8000, 32'h0000_8000, 33'h0_0000_FFFF, 1'b1);
    apply_check("upper_carry",  32'hFFFF_0000, 32'h0001_0000, 33'h1_0000_0000, 1'b0);
    apply_check("all_ones_p1",  32'hFFFF_FFFF, 32'h0000_0001, 33'h0_FFFF_FFFF, 1'b1);
    in_valid = 1'b0;
    @(posedge Clk); #1;
    check_out("hold_after", 1'b0, 33'h0_FFFF_FFFF, 1'b1);
    @(posedge Clk); #1;
    check_out("hold_after2", 1'b0, 33'h0_FFFF_FFFF, 1'b1);

    // Randomized traffic with mixed operand shapes
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_A   = $urandom;
      case ($urandom_range(0, 3))
        0: data_B = $urandom & ~data_A;
        1: data_B = $urandom & 32'h0000_FFFF;
        2: data_B = (32'd1 << $urandom_range(0, 31));
        default: data_B = $urandom;
      endcase
      @(posedge Clk); #1;
    end

    // Asynchronous reset asserted mid-stream, no clock edge needed
    in_valid = 1'b1;
    data_A   = 32'h1234_5678;
    data_B   = 32'h0F0F_0F0F;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, '0, 1'b0);
    @(posedge Clk); #1;
    check_out("reset_clocked", 1'b0, '0, 1'b0);
    #3 Rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    check_out("release_idle", 1'b0, '0, 1'b0);
    apply_check("after_reset", 32'h0000_0003, 32'h0000_0005, 33'h0_0000_0007, 1'b1);
    in_valid = 1'b0;
    @(posedge Clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/etai32_reg_adder.md
Name:
etai32_reg_adder

Overview:
- Registered 32-bit Error-Tolerant Adder type I (ETA-I): approximate adder for error-resilient datapaths.
- Operands split into an exact upper part (ripple/normal add) and an approximate carry-free lower part.
- Used as a drop-in approximate adder in the functional-unit library; output registered with 1-cycle latency.

Parameters:
- WIDTH, 32, operand width.
- LOWER, 16, number of LSBs in the inaccurate part; legal range 1..WIDTH-1.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- data_A  input  WIDTH  operand A (two's complement or unsigned; bit pattern only).
- data_B  input  WIDTH  operand B.
- out_valid  output  1  adder_out holds the result for the operands presented one cycle earlier.
- adder_out  output  WIDTH+1  approximate sum; bit WIDTH is carry-out of the upper part.

Behaviour:
- Reset (Rst_n=0, asynchronous, no clock needed): adder_out=0 and out_valid=0. Both remain 0 until the first valid capture after release.
- Lower part, bits LOWER-1..0, no carry chain, evaluated combinationally:
  - Scan from bit LOWER-1 down to bit 0.
  - Sum bit = A[i] XOR B[i] until the first (highest) position k where A[k]=B[k]=1.
  - Bit k and all bits below k are forced to 1.
  - If no such k exists, the lower sum = A XOR B, which is exact.
- Upper part, bits WIDTH-1..LOWER:
  - Exact unsigned addition of A[WIDTH-1:LOWER] + B[WIDTH-1:LOWER].
  - Carry-in is always 0; the lower part never propagates a carry.
  - The carry-out goes to adder_out[WIDTH].
- Width rule: adder_out[WIDTH-1:0] interpreted as a signed value gives the signed approximate sum. Bit WIDTH is the unsigned carry, not sign extension.
- Timing:
  - On the rising Clk edge with in_valid=1: adder_out <= approx(data_A, data_B); out_valid <= 1.
  - With in_valid=0: adder_out holds its value; out_valid <= 0.
  - Latency is exactly 1 cycle, throughput 1 result per cycle, no backpressure.
- Reset asserted mid-stream: the in-flight result is discarded and outputs go to 0 immediately.
- X on any operand bit yields X at the output; there is no X-masking.

Optional Feature:
- Macro ETAI_ERR_FLAG_EN.
- When defined:
  - Adds output port err_flag, 1 bit, registered alongside adder_out.
  - err_flag=1 iff the approximate WIDTH+1-bit result differs from the exact data_A+data_B (WIDTH+1 bits, zero-extended).
  - Reset value 0; holds when in_valid=0.
- When undefined: the port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset: hold Rst_n=0 with random operands and toggling Clk -> adder_out=0 and out_valid=0. Deasserting Rst_n asynchronously mid-cycle -> outputs stay 0 until the next valid capture.
- A=0x0000_1234, B=0x0000_0001, in_valid=1 -> next cycle adder_out=0x0_0000_1235, out_valid=1, err_flag=0 (no collision, exact).
- A=0x0000_00FF, B=0x0000_0001 -> adder_out=0x0_0000_00FF (collision at bit 0), err_flag=1 (exact sum 0x100).
- A=0x0000_8000, B=0x0000_8000 -> adder_out=0x0_0000_FFFF (collision at bit 15 saturates the lower part; no carry into the upper part), err_flag=1.
- A=0xFFFF_0000, B=0x0001_0000 -> adder_out=0x1_0000_0000 (upper carry-out). Then A=0xFFFF_FFFF, B=0x0000_0001 -> adder_out=0x0_FFFF_FFFF.
- Back-to-back: operands on 3 consecutive cycles, then in_valid=0 -> 3 results in order, each 1 cycle after its operands. After that, out_valid=0 and adder_out holds the last result.
